// File: rtl/accelerator_pkg.sv
// Shared widths, register map, fixed-point format and FSM encoding for the accelerator.
// The optional ReLU stage is controlled by the ACCELERATOR_RELU_EN macro.
package accelerator_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_W   = 32;
    localparam int ACC_W  = 32;
    localparam int FRAC    = 8;
    localparam int IN_MAX  = 64;
    localparam int OUT_MAX = 256;

    localparam logic [15:0] REG_IN_NO  = 16'h0000;
    localparam logic [15:0] REG_OUT_NO = 16'h0001;
    localparam logic [15:0] REG_CTRL   = 16'h0002;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            sat16 = 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

endpackage

// File: rtl/accelerator_mac.sv
// Signed 16x16 multiply-accumulate with clear, plus Q8.8 shift-and-saturate of the sum.
// The accumulator clamps at the 32-bit bounds so long dot products never wrap sign.
module accelerator_mac
    import accelerator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] result
);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W:0]   sum_s;

    // Product and widened sum for overflow detection
    always_comb begin
        prod_s = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        sum_s  = $signed({acc_r[ACC_W-1], acc_r}) + $signed({prod_s[ACC_W-1], prod_s});
    end

    // Saturating accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 32'sd0;
        end else if (clear) begin
            acc_r <= 32'sd0;
        end else if (en) begin
            if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
                acc_r <= sum_s[ACC_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign result = sat16(acc_r >>> FRAC);

endmodule

// File: rtl/accelerator.sv
// Fully-connected layer accelerator: register/memory write port, MAC sequencer, read port.
// Define ACCELERATOR_RELU_EN to make ctrl bit1 clip negative results to zero.
module accelerator
    import accelerator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              interrupt,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    output logic              read_rdy,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              read_data_rdy,
    output logic              read_data_vld,
    output logic [RD_W-1:0]   read_data
);

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [6:0]  in_no_r;
    logic [8:0]  out_no_r;
    logic [6:0]  i_r;
    logic [8:0]  j_r;
    logic [8:0]  out_valid_r;
    logic        interrupt_r;
    logic        write_rdy_r;
    logic        read_data_vld_r;
    logic [31:0] read_data_r;
`ifdef ACCELERATOR_RELU_EN
    logic        relu_r;
`endif

    logic [15:0] w_mem   [0:OUT_MAX*IN_MAX-1];
    logic [15:0] act_mem [0:IN_MAX-1];
    logic [15:0] out_mem [0:OUT_MAX-1];

    logic               busy_s;
    logic               wr_acc_s;
    logic               start_s;
    logic               wb_s;
    logic               last_s;
    logic               rd_acc_s;
    logic               rd_valid_s;
    logic [7:0]         rd_j_s;
    logic [15:0]        rd_act_s;
    logic signed [15:0] w_s;
    logic signed [15:0] x_s;
    logic signed [15:0] mac_out_s;
    logic signed [15:0] final_s;
    logic               unused_s;

    assign busy_s   = (state_r == ST_BUSY);
    assign wr_acc_s = write_en && write_rdy_r;
    assign start_s  = wr_acc_s && (write_addr == REG_CTRL) && write_data[0];
    // i_r reaching in_no marks the writeback cycle that closes output j
    assign wb_s     = busy_s && (i_r == in_no_r);
    assign last_s   = wb_s && (j_r == out_no_r - 9'd1);
    assign read_rdy = !busy_s && (!read_data_vld_r || read_data_rdy);
    assign rd_acc_s = read_en && read_rdy;
    assign unused_s = ^read_addr[9:6];

    assign w_s = w_mem[{j_r[7:0], i_r[5:0]}];
    assign x_s = act_mem[i_r[5:0]];

    accelerator_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_s || wb_s),
        .en     (busy_s && !wb_s),
        .a      (w_s),
        .b      (x_s),
        .result (mac_out_s)
    );

    // Optional rectification of the finished result
    always_comb begin
        final_s = mac_out_s;
`ifdef ACCELERATOR_RELU_EN
        if (relu_r && mac_out_s[15]) begin
            final_s = 16'sd0;
        end else begin
            final_s = mac_out_s;
        end
`endif
    end

    // Next-state decode; a start with no outputs skips straight to DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = (out_no_r == 9'd0) ? ST_DONE : ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (start_s) begin
                    state_next_s = (out_no_r == 9'd0) ? ST_DONE : ST_BUSY;
                end else if (wr_acc_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control state, configuration registers and loop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            interrupt_r <= 1'b0;
            write_rdy_r <= 1'b1;
            in_no_r     <= 7'd0;
            out_no_r    <= 9'd0;
            i_r         <= 7'd0;
            j_r         <= 9'd0;
            out_valid_r <= 9'd0;
`ifdef ACCELERATOR_RELU_EN
            relu_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_next_s;
            interrupt_r <= (state_next_s == ST_DONE);
            write_rdy_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_DONE);
            if (wr_acc_s && (write_addr == REG_IN_NO)) begin
                in_no_r <= (write_data[6:0] > 7'(IN_MAX)) ? 7'(IN_MAX) : write_data[6:0];
            end
            if (wr_acc_s && (write_addr == REG_OUT_NO)) begin
                out_no_r <= (write_data[8:0] > 9'(OUT_MAX)) ? 9'(OUT_MAX) : write_data[8:0];
            end
`ifdef ACCELERATOR_RELU_EN
            if (wr_acc_s && (write_addr == REG_CTRL)) begin
                relu_r <= write_data[1];
            end
`endif
            if (start_s) begin
                i_r         <= 7'd0;
                j_r         <= 9'd0;
                out_valid_r <= 9'd0;
            end else if (wb_s) begin
                i_r         <= 7'd0;
                j_r         <= j_r + 9'd1;
                out_valid_r <= j_r + 9'd1;
            end else if (busy_s) begin
                i_r <= i_r + 7'd1;
            end
        end
    end

    // Weight, activation and result storage (not reset)
    always_ff @(posedge clk) begin
        if (wr_acc_s && write_addr[15]) begin
            w_mem[write_addr[13:0]] <= write_data;
        end
        if (wr_acc_s && (write_addr[15:14] == 2'b01)) begin
            act_mem[write_addr[5:0]] <= write_data;
        end
        if (wb_s) begin
            out_mem[j_r[7:0]] <= final_s;
        end
    end

    // Output j lives at PE j%64, address j/64; only finished outputs are visible
    always_comb begin
        rd_j_s     = {read_addr[1:0], read_addr[15:10]};
        rd_valid_s = (read_addr[5:2] == 4'd0) && ({1'b0, rd_j_s} < out_valid_r);
        if (rd_valid_s) begin
            rd_act_s = out_mem[rd_j_s];
        end else begin
            rd_act_s = 16'h0000;
        end
    end

    // Read response register with valid/ready hold
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_vld_r <= 1'b0;
            read_data_r     <= 32'h0000_0000;
        end else if (rd_acc_s) begin
            read_data_vld_r <= 1'b1;
            read_data_r     <= {4'b0000, read_addr[5:0], read_addr[15:10], rd_act_s};
        end else if (read_data_rdy) begin
            read_data_vld_r <= 1'b0;
        end
    end

    assign interrupt     = interrupt_r;
    assign write_rdy     = write_rdy_r;
    assign read_data_vld = read_data_vld_r;
    assign read_data     = read_data_r;

endmodule

// File: tb/tb_accelerator.sv
// Self-checking bench for accelerator: fixed read tables, latency checks, randomized layers
// against a dot-product reference model, backpressure and abort sequences.
module tb_accelerator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interrupt;
    logic        write_en = 1'b0;
    logic        write_rdy;
    logic [15:0] write_addr = 16'h0;
    logic [15:0] write_data = 16'h0;
    logic        read_en = 1'b0;
    logic        read_rdy;
    logic [15:0] read_addr = 16'h0;
    logic        read_data_rdy = 1'b1;
    logic        read_data_vld;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    int w_m [256][64];
    int a_m [64];
    int out_m [256];
    int m_in_no, m_out_no, m_valid;
    bit m_relu;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[$];

    accelerator dut (
        .clk           (clk),
        .rst           (rst),
        .interrupt     (interrupt),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .read_en       (read_en),
        .read_rdy      (read_rdy),
        .read_addr     (read_addr),
        .read_data_rdy (read_data_rdy),
        .read_data_vld (read_data_vld),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: saturating dot product, Q8.8 scaling, 16-bit clamp, optional rectification
    function automatic void model_run();
        for (int j = 0; j < m_out_no; j++) begin
            longint acc = 0;
            longint r;
            for (int i = 0; i < m_in_no; i++) begin
                acc = clampl(acc + longint'(w_m[j][i]) * longint'(a_m[i]), -64'sd2147483648, 64'sd2147483647);
            end
            r = clampl(acc >>> 8, -64'sd32768, 64'sd32767);
            if (m_relu && r < 0) r = 0;
            out_m[j] = int'(r);
        end
        m_valid = m_out_no;
    endfunction

    function automatic logic [31:0] exp_read(input logic [15:0] addr);
        int pe, act, j;
        logic [15:0] d;
        pe = int'(addr[15:10]);
        act = int'(addr[5:0]);
        j = act * 64 + pe;
        d = 16'h0000;
        if (act < 4 && j < m_valid) d = 16'(out_m[j]);
        return {4'h0, 12'(j), d};
    endfunction

    task automatic model_reset();
        m_in_no = 0; m_out_no = 0; m_valid = 0; m_relu = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        int n = 0;
        while (!write_rdy && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!write_rdy) check("write_rdy_wait", {31'b0, write_rdy}, 32'd1);
        write_en = 1'b1; write_addr = addr; write_data = data;
        @(posedge clk); #1;
        write_en = 1'b0;
        if (addr == 16'h0000) m_in_no = (int'(data[6:0]) > 64) ? 64 : int'(data[6:0]);
        else if (addr == 16'h0001) m_out_no = (int'(data[8:0]) > 256) ? 256 : int'(data[8:0]);
        else if (addr == 16'h0002) begin
`ifdef ACCELERATOR_RELU_EN
            m_relu = data[1];
`endif
            if (data[0]) model_run();
        end
        else if (addr[15:14] == 2'b01) a_m[addr[5:0]] = $signed(data);
        else if (addr[15]) w_m[addr[13:6]][addr[5:0]] = $signed(data);
    endtask

    task automatic wait_irq(input int exp_lat, input string name);
        int n = 0;
        while (!interrupt && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check(name, n, exp_lat);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
        int n = 0;
        while (!read_rdy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!read_rdy) check("read_rdy_wait", {31'b0, read_rdy}, 32'd1);
        read_en = 1'b1; read_addr = addr;
        @(posedge clk); #1;
        read_en = 1'b0;
        check({name, "_vld"}, {31'b0, read_data_vld}, 32'd1);
        check(name, read_data, exp);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[k]) rd(tbl[k].addr, tbl[k].exp, $sformatf("%s_%0d", tag, k));
        tbl.delete();
    endtask

    initial begin
        int in_no, out_no;
        logic [15:0] ra, rb;
        logic [31:0] ea, eb;
        bit irq_seen;

        for (int j = 0; j < 256; j++) begin
            out_m[j] = 0;
            for (int i = 0; i < 64; i++) w_m[j][i] = 0;
        end
        for (int i = 0; i < 64; i++) a_m[i] = 0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_irq", {31'b0, interrupt}, 32'd0);
        check("rst_vld", {31'b0, read_data_vld}, 32'd0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_wrdy", {31'b0, write_rdy}, 32'd1);
        check("rst_rrdy", {31'b0, read_rdy}, 32'd1);

        // Two-input single-output example
        do_write(16'h4000, 16'h0100);
        do_write(16'h4001, 16'h0200);
        do_write(16'h8000, 16'h0100);
        do_write(16'h8001, 16'h0100);
        do_write(16'h0000, 16'd2);
        do_write(16'h0001, 16'd1);
        do_write(16'h0002, 16'h0001);
        check("busy_wrdy", {31'b0, write_rdy}, 32'd0);
        check("busy_rrdy", {31'b0, read_rdy}, 32'd0);
        wait_irq(3, "lat_basic");
        tbl.push_back('{16'h0000, 32'h0000_0300});
        tbl.push_back('{16'h0400, 32'h0001_0000});
        tbl.push_back('{16'h0004, 32'h0100_0000});
        run_table("basic");
        do_write(16'h0000, 16'd1);
        check("done_to_idle_irq", {31'b0, interrupt}, 32'd0);
        check("done_to_idle_wrdy", {31'b0, write_rdy}, 32'd1);

        // 65 outputs: second PE address row
        do_write(16'h4000, 16'h0100);
        for (int j = 0; j < 65; j++) do_write(16'(32'h8000 + j * 64), 16'(j * 16));
        do_write(16'h0000, 16'd1);
        do_write(16'h0001, 16'd65);
        do_write(16'h0002, 16'h0001);
        wait_irq(130, "lat_65");
        tbl.push_back('{16'h0001, 32'h0040_0400});
        tbl.push_back('{16'hFC00, 32'h003F_03F0});
        tbl.push_back('{16'h0401, 32'h0041_0000});
        tbl.push_back('{16'h0802, 32'h0082_0000});
        tbl.push_back('{16'h0400, 32'h0001_0010});
        run_table("pe65");

        // Saturation both ways
        for (int i = 0; i < 64; i++) begin
            do_write(16'(32'h4000 + i), 16'h7F00);
            do_write(16'(32'h8000 + i), 16'h7F00);
            do_write(16'(32'h8040 + i), 16'h8100);
        end
        do_write(16'h0000, 16'd64);
        do_write(16'h0001, 16'd2);
        do_write(16'h0002, 16'h0001);
        wait_irq(130, "lat_sat");
        tbl.push_back('{16'h0000, 32'h0000_7FFF});
        tbl.push_back('{16'h0400, 32'h0001_8000});
        run_table("sat");
`ifdef ACCELERATOR_RELU_EN
        do_write(16'h0002, 16'h0003);
        wait_irq(130, "lat_relu");
        tbl.push_back('{16'h0000, 32'h0000_7FFF});
        tbl.push_back('{16'h0400, 32'h0001_0000});
        run_table("relu");
`endif

        // out_no = 0 reaches DONE on the next cycle
        do_write(16'h0001, 16'd0);
        do_write(16'h0002, 16'h0001);
        wait_irq(0, "lat_zero");
        rd(16'h0000, 32'h0000_0000, "zero_out");

        // Randomized layers against the model
        for (int it = 0; it < 3; it++) begin
            in_no  = (it == 2) ? int'($urandom_range(2, 1)) : int'($urandom_range(8, 1));
            out_no = (it == 2) ? int'($urandom_range(70, 66)) : int'($urandom_range(12, 1));
            for (int i = 0; i < in_no; i++) do_write(16'(32'h4000 + i), 16'($urandom));
            for (int j = 0; j < out_no; j++)
                for (int i = 0; i < in_no; i++) do_write(16'(32'h8000 + j * 64 + i), 16'($urandom));
            do_write(16'h0000, 16'(in_no));
            do_write(16'h0001, 16'(out_no));
            do_write(16'h0002, {14'b0, 1'($urandom), 1'b1});
            wait_irq(out_no * (in_no + 1), $sformatf("lat_rand%0d", it));
            for (int j = 0; j <= out_no; j++) begin
                ra = {6'(j % 64), 4'($urandom), 6'(j / 64)};
                rd(ra, exp_read(ra), $sformatf("rand%0d_j%0d", it, j));
            end
        end

        // Backpressure: response held until consumed, then back-to-back read
        @(posedge clk); #1;
        read_data_rdy = 1'b0;
        ra = 16'h0000; rb = 16'h0400;
        ea = exp_read(ra); eb = exp_read(rb);
        rd(ra, ea, "bp_first");
        read_en = 1'b1; read_addr = rb;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_hold_vld", {31'b0, read_data_vld}, 32'd1);
            check("bp_hold_data", read_data, ea);
            check("bp_hold_rrdy", {31'b0, read_rdy}, 32'd0);
        end
        read_data_rdy = 1'b1;
        #1 check("bp_release_rrdy", {31'b0, read_rdy}, 32'd1);
        @(posedge clk); #1;
        read_en = 1'b0;
        check("bp_next_vld", {31'b0, read_data_vld}, 32'd1);
        check("bp_next_data", read_data, eb);
        @(posedge clk); #1;
        check("bp_vld_clear", {31'b0, read_data_vld}, 32'd0);

        // Write during BUSY is dropped; reset mid-BUSY aborts
        for (int i = 0; i < 3; i++) begin
            do_write(16'(32'h4000 + i), 16'(32'h0040 * (i + 1)));
            do_write(16'(32'h8000 + i), 16'(32'h0100 + i));
            do_write(16'(32'h8040 + i), 16'(32'hFF00 - i));
        end
        do_write(16'h0000, 16'd3);
        do_write(16'h0001, 16'd2);
        do_write(16'h0002, 16'h0001);
        check("drop_wrdy", {31'b0, write_rdy}, 32'd0);
        write_en = 1'b1; write_addr = 16'h0000; write_data = 16'd5;
        @(posedge clk); #1;
        write_en = 1'b0;
        wait_irq(7, "lat_drop");
        rd(16'h0000, exp_read(16'h0000), "drop_res0");
        rd(16'h0400, exp_read(16'h0400), "drop_res1");
        do_write(16'h0002, 16'h0001);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("abort_irq", {31'b0, interrupt}, 32'd0);
        check("abort_wrdy", {31'b0, write_rdy}, 32'd1);
        check("abort_rrdy", {31'b0, read_rdy}, 32'd1);
        check("abort_vld", {31'b0, read_data_vld}, 32'd0);
        irq_seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (interrupt) irq_seen = 1'b1;
        end
        check("abort_irq_quiet", {31'b0, irq_seen}, 32'd0);
        rd(16'h0000, 32'h0000_0000, "abort_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
